// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bus between the memory stage and the dcache.
// The memory stage drives requests (master); the dcache answers with hit/data (slave).
interface mem_access_unit_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues dcache requests for the instruction in
// EX/MEM, freezes the upstream pipeline while a request is outstanding, keeps
// the LL/SC link register, and drives the MEM/WB enable/flush controls.
module mem_access_unit #(
  parameter int CNT_W          = 16,
  parameter bit LINK_CLR_ON_ST = 1'b1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ex_valid,
  input  logic               ex_dREN,
  input  logic               ex_dWEN,
  input  logic               ex_ll,
  input  logic               ex_sc,
  input  logic               ex_halt,
  input  logic [31:0]        ex_addr,
  input  logic [31:0]        ex_store,
  input  logic               ext_stall,
  input  logic               snoop_inv,
  input  logic [31:0]        snoop_addr,
  mem_access_unit_if.master  dbus,
  output logic [31:0]        mem_data,
  output logic               mem_stall,
  output logic               memwb_en,
  output logic               memwb_flush,
  output logic               halted,
  output logic [CNT_W-1:0]   stat_wait
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic               link_valid_reg, link_valid_next;
  logic [29:0]        link_addr_reg, link_addr_next;
  logic [31:0]        hold_data_reg, hold_data_next;
  logic [CNT_W-1:0]   stat_wait_reg, stat_wait_next;

  logic        mem_op;
  logic        sc_ok;
  logic        sc_fail;
  logic        req;
  logic        done;
  logic [29:0] ex_word;
  logic [31:0] sc_result;
  logic [31:0] capture_data;
  logic        unused_bits;

  // Word-granular addresses: the byte offset never participates in matching.
  assign unused_bits  = ^{ex_addr[1:0], snoop_addr[1:0]};
  assign ex_word      = ex_addr[31:2];

  assign mem_op       = ex_valid & (ex_dREN | ex_dWEN);
  assign sc_ok        = link_valid_reg & (link_addr_reg == ex_word);
  assign sc_fail      = mem_op & ex_sc & ~sc_ok;
  // nRST gates the request so the cache sees nothing while reset is held.
  assign req          = nRST & mem_op & ~sc_fail &
                        ((state_reg == IDLE) | (state_reg == WAIT));
  assign done         = req & dbus.dhit;
  assign sc_result    = {31'b0, sc_ok};
  assign capture_data = ex_sc ? sc_result : dbus.dmemload;

  assign dbus.dmemREN   = req & ex_dREN;
  assign dbus.dmemWEN   = req & ex_dWEN;
  assign dbus.dmemaddr  = {ex_addr[31:2], 2'b00};
  assign dbus.dmemstore = ex_store;

  assign halted      = (state_reg == HALT);
  assign mem_stall   = req & ~dbus.dhit;
  assign memwb_en    = ~ext_stall & ~mem_stall & ~halted;
  assign memwb_flush = mem_stall & ~ext_stall;
  assign stat_wait   = stat_wait_reg;

  // Result toward MEM/WB: captured value while held, SC status flag, else cache data.
  always_comb begin
    mem_data = dbus.dmemload;
    if (state_reg == HOLD) begin
      mem_data = hold_data_reg;
    end else if (ex_sc) begin
      mem_data = sc_result;
    end
  end

  // Next-state and hold-data capture for the request sequencer.
  always_comb begin
    state_next     = state_reg;
    hold_data_next = hold_data_reg;
    case (state_reg)
      IDLE: begin
        if (req && !dbus.dhit) begin
          state_next = WAIT;
        end else if (req && dbus.dhit && ext_stall) begin
          state_next     = HOLD;
          hold_data_next = capture_data;
        end else if (ex_valid && ex_halt && !ext_stall) begin
          state_next = HALT;
        end
      end
      WAIT: begin
        // A request that vanishes (e.g. SC losing its link) must not strand us here.
        if (!req) begin
          state_next = IDLE;
        end else if (dbus.dhit) begin
          if (ext_stall) begin
            state_next     = HOLD;
            hold_data_next = capture_data;
          end else begin
            state_next = IDLE;
          end
        end
      end
      HOLD: begin
        if (!ext_stall) begin
          state_next = IDLE;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Link register update; later assignments take priority, so an LL set beats a snoop clear.
  always_comb begin
    link_valid_next = link_valid_reg;
    link_addr_next  = link_addr_reg;
    if (snoop_inv && (snoop_addr[31:2] == link_addr_reg)) begin
      link_valid_next = 1'b0;
    end
    if (LINK_CLR_ON_ST && done && ex_dWEN && !ex_sc && (ex_word == link_addr_reg)) begin
      link_valid_next = 1'b0;
    end
    if ((done && ex_sc) || sc_fail) begin
      link_valid_next = 1'b0;
    end
    if (done && ex_dREN && ex_ll) begin
      link_valid_next = 1'b1;
      link_addr_next  = ex_word;
    end
  end

  // Saturating count of cycles spent stalling on the dcache.
  always_comb begin
    stat_wait_next = stat_wait_reg;
    if (mem_stall && (stat_wait_reg != {CNT_W{1'b1}})) begin
      stat_wait_next = stat_wait_reg + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      link_valid_reg <= 1'b0;
      link_addr_reg  <= '0;
      hold_data_reg  <= '0;
      stat_wait_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      link_valid_reg <= link_valid_next;
      link_addr_reg  <= link_addr_next;
      hold_data_reg  <= hold_data_next;
      stat_wait_reg  <= stat_wait_next;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// LW/SW/LL/SC traffic compared against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int K_LW = 0;
  localparam int K_SW = 1;
  localparam int K_LL = 2;
  localparam int K_SC = 3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ex_valid, ex_dREN, ex_dWEN, ex_ll, ex_sc, ex_halt;
  logic [31:0] ex_addr, ex_store;
  logic        ext_stall, snoop_inv;
  logic [31:0] snoop_addr;
  logic [31:0] mem_data;
  logic        mem_stall, memwb_en, memwb_flush, halted;
  logic [15:0] stat_wait;

  // Second, narrow-counter instance for saturation.
  logic        s_valid;
  logic [31:0] s_mem_data;
  logic        s_mem_stall, s_memwb_en, s_memwb_flush, s_halted;
  logic [3:0]  s_stat_wait;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: link register and total expected stall cycles.
  bit          m_link_valid;
  logic [29:0] m_link_word;
  int          m_wait;

  always #5 CLK = ~CLK;

  mem_access_unit_if dbus ();
  mem_access_unit_if sbus ();

  mem_access_unit #(.CNT_W(16), .LINK_CLR_ON_ST(1'b1)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_ll(ex_ll), .ex_sc(ex_sc), .ex_halt(ex_halt),
    .ex_addr(ex_addr), .ex_store(ex_store),
    .ext_stall(ext_stall), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dbus(dbus.master),
    .mem_data(mem_data), .mem_stall(mem_stall), .memwb_en(memwb_en),
    .memwb_flush(memwb_flush), .halted(halted), .stat_wait(stat_wait)
  );

  mem_access_unit #(.CNT_W(4), .LINK_CLR_ON_ST(1'b1)) dut_sat (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(s_valid), .ex_dREN(1'b1), .ex_dWEN(1'b0),
    .ex_ll(1'b0), .ex_sc(1'b0), .ex_halt(1'b0),
    .ex_addr(32'h0000_0400), .ex_store(32'h0000_55AA),
    .ext_stall(1'b0), .snoop_inv(1'b0), .snoop_addr(32'h0),
    .dbus(sbus.master),
    .mem_data(s_mem_data), .mem_stall(s_mem_stall), .memwb_en(s_memwb_en),
    .memwb_flush(s_memwb_flush), .halted(s_halted), .stat_wait(s_stat_wait)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_dREN = 1'b0; ex_dWEN = 1'b0; ex_ll = 1'b0;
    ex_sc = 1'b0; ex_halt = 1'b0; ext_stall = 1'b0; snoop_inv = 1'b0;
    dbus.dhit = 1'b0;
  endtask

  // One memory instruction: lat miss cycles, then hit; hold>0 keeps ext_stall
  // up from the hit cycle for hold cycles, then releases. snp_hit raises a
  // snoop to the same word on the hit cycle.
  task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] data,
                       input int lat, input int hold, input bit snp_hit);
    bit          is_load, has_data, ok, fail;
    logic [31:0] exp_data, store_val, later_load;
    is_load    = (kind == K_LW) || (kind == K_LL);
    has_data   = is_load || (kind == K_SC);
    ok         = m_link_valid && (m_link_word == addr[31:2]);
    fail       = (kind == K_SC) && !ok;
    exp_data   = (kind == K_SC) ? {31'b0, ok} : data;
    store_val  = $urandom;
    later_load = (data == 32'hFFFF_FFFF) ? 32'h0 : 32'hFFFF_FFFF;
    ex_valid = 1'b1; ex_dREN = is_load; ex_dWEN = !is_load;
    ex_ll = (kind == K_LL); ex_sc = (kind == K_SC); ex_halt = 1'b0;
    ex_addr = addr; ex_store = store_val; snoop_inv = 1'b0; ext_stall = 1'b0;
    if (fail) begin
      dbus.dhit = 1'b0; dbus.dmemload = $urandom;
      @(negedge CLK);
      check_val("scfail_ren", 32'(dbus.dmemREN), 32'd0);
      check_val("scfail_wen", 32'(dbus.dmemWEN), 32'd0);
      check_val("scfail_stall", 32'(mem_stall), 32'd0);
      check_val("scfail_en", 32'(memwb_en), 32'd1);
      check_val("scfail_data", mem_data, 32'd0);
      @(posedge CLK); #1;
      m_link_valid = 1'b0;
    end else begin
      for (int i = 0; i <= lat; i++) begin
        dbus.dhit     = (i == lat);
        dbus.dmemload = (i == lat) ? data : $urandom;
        ext_stall     = (i == lat) && (hold > 0);
        snoop_inv     = (i == lat) && snp_hit;
        snoop_addr    = addr;
        @(negedge CLK);
        check_val("req_ren", 32'(dbus.dmemREN), 32'(is_load));
        check_val("req_wen", 32'(dbus.dmemWEN), 32'(!is_load));
        check_val("req_addr", dbus.dmemaddr, {addr[31:2], 2'b00});
        check_val("req_store", dbus.dmemstore, store_val);
        check_val("req_stall", 32'(mem_stall), 32'(i < lat));
        check_val("req_flush", 32'(memwb_flush), 32'(i < lat));
        check_val("req_en", 32'(memwb_en), 32'((i == lat) && (hold == 0)));
        if ((i == lat) && has_data) check_val("hit_data", mem_data, exp_data);
        @(posedge CLK); #1;
      end
      snoop_inv = 1'b0;
      m_wait += lat;
      if (snp_hit && m_link_valid && (m_link_word == addr[31:2])) m_link_valid = 1'b0;
      if (kind == K_LL) begin
        m_link_valid = 1'b1; m_link_word = addr[31:2];
      end else if (kind == K_SC) begin
        m_link_valid = 1'b0;
      end else if ((kind == K_SW) && (m_link_word == addr[31:2])) begin
        m_link_valid = 1'b0;
      end
      for (int j = 1; j <= hold; j++) begin
        dbus.dhit = 1'b0; dbus.dmemload = later_load;
        ext_stall = (j < hold);
        @(negedge CLK);
        check_val("hold_ren", 32'(dbus.dmemREN), 32'd0);
        check_val("hold_wen", 32'(dbus.dmemWEN), 32'd0);
        check_val("hold_stall", 32'(mem_stall), 32'd0);
        check_val("hold_flush", 32'(memwb_flush), 32'd0);
        check_val("hold_en", 32'(memwb_en), 32'(j == hold));
        if (has_data) check_val("hold_data", mem_data, exp_data);
        @(posedge CLK); #1;
      end
    end
    idle_inputs();
    check_val("stat_wait", 32'(stat_wait), 32'(m_wait));
    $display("[TB] op=%0d addr=0x%08h lat=%0d hold=%0d sc_ok=%0b link=%0b",
             kind, addr, lat, hold, ok, m_link_valid);
  endtask

  // Bubble cycle with an optional snoop invalidate.
  task automatic bubble(input bit snp, input logic [31:0] saddr);
    idle_inputs();
    snoop_inv = snp; snoop_addr = saddr;
    @(negedge CLK);
    check_val("bub_ren", 32'(dbus.dmemREN), 32'd0);
    check_val("bub_wen", 32'(dbus.dmemWEN), 32'd0);
    check_val("bub_stall", 32'(mem_stall), 32'd0);
    check_val("bub_en", 32'(memwb_en), 32'd1);
    @(posedge CLK); #1;
    if (snp && m_link_valid && (saddr[31:2] == m_link_word)) m_link_valid = 1'b0;
    snoop_inv = 1'b0;
  endtask

  initial begin
    logic [31:0] pool [4];
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h204; pool[3] = 32'h300;
    idle_inputs();
    ex_addr = 32'h0; ex_store = 32'h0; snoop_addr = 32'h0; dbus.dmemload = 32'h0;
    s_valid = 1'b0; sbus.dhit = 1'b0; sbus.dmemload = 32'hA5A5_0001;
    m_link_valid = 1'b0; m_link_word = '0; m_wait = 0;
    nRST = 1'b0;
    #2;
    check_val("rst_ren", 32'(dbus.dmemREN), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_stat", 32'(stat_wait), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // Narrow counter saturates after 20 miss cycles.
    s_valid = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    check_val("sat_stat", 32'(s_stat_wait), 32'd15);
    check_val("sat_stall", 32'(s_mem_stall), 32'd1);
    check_val("sat_flush", 32'(s_memwb_flush), 32'd1);
    check_val("sat_en", 32'(s_memwb_en), 32'd0);
    check_val("sat_halted", 32'(s_halted), 32'd0);
    check_val("sat_data", s_mem_data, 32'hA5A5_0001);
    check_val("sat_ren", 32'(sbus.dmemREN), 32'd1);
    check_val("sat_wen", 32'(sbus.dmemWEN), 32'd0);
    check_val("sat_addr", sbus.dmemaddr, 32'h400);
    check_val("sat_store", sbus.dmemstore, 32'h55AA);
    s_valid = 1'b0;
    $display("[TB] saturation run: stat_wait=%0d", s_stat_wait);

    // Directed scenarios.
    do_op(K_LW, 32'h100, 32'hDEAD_BEEF, 3, 0, 1'b0);
    do_op(K_LW, 32'h104, 32'h1234_5678, 0, 3, 1'b0);
    do_op(K_LL, 32'h200, 32'h0000_0777, 1, 0, 1'b0);
    do_op(K_SC, 32'h200, 32'h0, 0, 0, 1'b0);
    do_op(K_LL, 32'h200, 32'h0000_0777, 0, 0, 1'b0);
    bubble(1'b1, 32'h200);
    do_op(K_SC, 32'h200, 32'h0, 0, 0, 1'b0);
    do_op(K_LL, 32'h200, 32'h0000_0777, 0, 0, 1'b0);
    bubble(1'b1, 32'h204);
    do_op(K_SC, 32'h200, 32'h0, 2, 2, 1'b0);
    do_op(K_LL, 32'h200, 32'h0000_0888, 0, 0, 1'b1);
    do_op(K_SC, 32'h201, 32'h0, 0, 0, 1'b0);
    do_op(K_LL, 32'h300, 32'h0000_0999, 0, 0, 1'b0);
    do_op(K_SW, 32'h300, 32'h0, 1, 0, 1'b0);
    do_op(K_SC, 32'h300, 32'h0, 0, 0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      int kind, lat, hold;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      a    = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      lat  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_op(kind, a, $urandom, lat, hold, 1'b0);
      if ($urandom_range(0, 1) == 1) bubble(1'b1, pool[$urandom_range(0, 3)]);
    end

    // Reset while waiting on a miss.
    do_op(K_LL, 32'h200, 32'h0, 0, 0, 1'b0);
    ex_valid = 1'b1; ex_dREN = 1'b1; ex_addr = 32'h100; dbus.dhit = 1'b0;
    @(negedge CLK);
    check_val("pre_rst_ren", 32'(dbus.dmemREN), 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check_val("rst_wait_ren", 32'(dbus.dmemREN), 32'd0);
    check_val("rst_wait_stall", 32'(mem_stall), 32'd0);
    check_val("rst_wait_stat", 32'(stat_wait), 32'd0);
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    m_link_valid = 1'b0; m_wait = 0;
    $display("[TB] reset during WAIT");
    do_op(K_SC, 32'h200, 32'h0, 0, 0, 1'b0);

    // HALT, then a load that must not issue.
    ex_valid = 1'b1; ex_halt = 1'b1;
    @(negedge CLK);
    check_val("halt_pre", 32'(halted), 32'd0);
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    check_val("halted", 32'(halted), 32'd1);
    check_val("halt_en", 32'(memwb_en), 32'd0);
    @(posedge CLK); #1;
    ex_valid = 1'b1; ex_dREN = 1'b1; ex_addr = 32'h300;
    @(negedge CLK);
    check_val("halt_ren", 32'(dbus.dmemREN), 32'd0);
    check_val("halt_stall", 32'(mem_stall), 32'd0);
    check_val("halt_en2", 32'(memwb_en), 32'd0);
    check_val("halt_stay", 32'(halted), 32'd1);
    @(posedge CLK); #1;
    idle_inputs();
    $display("[TB] halt sequence");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
